// File: rtl/instruction_fetch_unit_pkg.sv
// Shared widths, the buffered fetch entry and the end-of-image test used by the fetch unit.
package instruction_fetch_unit_pkg;

    localparam int unsigned XLEN        = 64;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // True when a word starting at pc would extend past the memory image.
    // Computed one bit wider so pc values near 2^64 do not wrap into range.
    function automatic logic past_image(input logic [XLEN-1:0] pc, input int unsigned mem_bytes);
        logic [XLEN:0] end_addr;
        end_addr = {1'b0, pc} + (XLEN+1)'(INSTR_BYTES);
        return end_addr > (XLEN+1)'(mem_bytes);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; the head is held in a register so it keeps
// its last value while the FIFO is empty.
module instruction_fetch_unit_fetch_fifo
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(Depth):0] count_o,
    output logic                   full_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    typedef logic [PtrW:0]   cnt_t;
    typedef logic [PtrW-1:0] ptr_t;

    fetch_entry_t mem_q [Depth];
    fetch_entry_t head_q, head_d;
    ptr_t         rd_ptr_q, rd_ptr_d;
    ptr_t         wr_ptr_q, wr_ptr_d;
    cnt_t         count_q, count_d;
    logic         push, pop;

    assign full_o  = (count_q == cnt_t'(Depth));
    assign pop     = pop_i & (count_q != '0);
    assign push    = push_i & (~full_o | pop);
    assign head_o  = head_q;
    assign count_o = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
            // The incoming entry becomes the head when nothing older survives this edge.
            if (count_d != '0) begin
                head_d = (count_q == cnt_t'(pop)) ? push_data_i : mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            head_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push && !flush_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            head_q   <= head_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, captures the same-cycle memory word, queues {pc, instr}
// pairs for decode, and handles branch redirect and end-of-image halt.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
    parameter int unsigned     MEM_BYTES = 16,
    parameter int unsigned     DEPTH     = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [XLEN-1:0]    Inst_Addr,
    input  logic [INSTR_W-1:0] Instruction,
    input  logic               branch_taken,
    input  logic [XLEN-1:0]    branch_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc,
    output logic               halted
);

    logic [XLEN-1:0]        pc_q, pc_d;
    logic [XLEN-1:0]        pc_inc, redirect_pc;
    logic                   halted_q, halted_d;
    logic                   fifo_full, pop, fetch_en;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   unused_target_lsbs;
    fetch_entry_t           push_entry, head;

    assign pc_inc             = pc_q + XLEN'(INSTR_BYTES);
    assign redirect_pc        = {branch_target[XLEN-1:2], 2'b00};
    assign unused_target_lsbs = ^branch_target[1:0];

    assign pop        = out_valid & out_ready;
    assign fetch_en   = ~halted_q & ~branch_taken & (~fifo_full | pop);
    assign push_entry = '{pc: pc_q, instr: Instruction};

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        if (branch_taken) begin
            pc_d     = redirect_pc;
            halted_d = past_image(redirect_pc, MEM_BYTES);
        end else if (fetch_en) begin
            pc_d     = pc_inc;
            halted_d = past_image(pc_inc, MEM_BYTES);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    // Redirect flushes the queue and overrides any pop presented in the same cycle.
    instruction_fetch_unit_fetch_fifo #(
        .Depth(DEPTH)
    ) u_fetch_fifo (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .flush_i    (branch_taken),
        .push_i     (fetch_en),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (fifo_count),
        .full_o     (fifo_full)
    );

    assign Inst_Addr = pc_q;
    assign out_valid = (fifo_count != '0);
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign halted    = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a queue-based reference model predicts fetches,
// and a negedge monitor compares the DUT's address, halt flag and handshaked outputs.
module tb_instruction_fetch_unit;

    localparam int unsigned MemBytes = 64;
    localparam int unsigned Depth    = 4;
    localparam int unsigned Words    = MemBytes / 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] Inst_Addr;
    logic [31:0] Instruction;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        halted;

    instruction_fetch_unit #(
        .RESET_PC (64'h0),
        .MEM_BYTES(MemBytes),
        .DEPTH    (Depth)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .Inst_Addr    (Inst_Addr),
        .Instruction  (Instruction),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [Words];
    assign Instruction = (Inst_Addr < 64'(MemBytes)) ? imem[int'(Inst_Addr >> 2)] : 32'hDEAD_BEEF;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] m_pc     = 64'h0;
    bit          m_halted = 1'b0;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    endtask

    // A word at address a does not fit when it starts after the last full word slot.
    function automatic bit beyond_image(input logic [63:0] a);
        return a > 64'(MemBytes - 4);
    endfunction

    // Reference model: the queue holds every fetched, not yet consumed {pc, instr} pair.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pc     = 64'h0;
            m_halted = 1'b0;
            exp_q.delete();
        end else if (branch_taken) begin
            exp_q.delete();
            m_pc     = branch_target & ~64'h3;
            m_halted = beyond_image(m_pc);
        end else if (!m_halted && exp_q.size() < Depth) begin
            exp_q.push_back('{pc: m_pc, instr: imem[int'(m_pc >> 2)]});
            m_pc     = m_pc + 64'd4;
            m_halted = beyond_image(m_pc);
        end
    end

    // Monitor: consumes the expected head whenever the model says a handshake is due.
    always @(negedge clk) begin
        if (reset_n) begin
            exp_t e;
            check("inst_addr", Inst_Addr, m_pc);
            check("halted", {63'h0, halted}, {63'h0, m_halted});
            check("out_valid", {63'h0, out_valid}, {63'h0, exp_q.size() != 0});
            if (exp_q.size() != 0 && out_ready) begin
                e = exp_q.pop_front();
                check("out_pc", out_pc, e.pc);
                check("out_instr", {32'h0, out_instr}, {32'h0, e.instr});
            end
        end
    end

    task automatic step(input bit rdy, input bit br, input logic [63:0] tgt);
        out_ready     = rdy;
        branch_taken  = br;
        branch_target = tgt;
        @(posedge clk);
        #1;
    endtask

    // Reset is asserted between clock edges and its effect is checked before the next edge.
    task automatic do_reset();
        out_ready     = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 64'h0;
        reset_n       = 1'b0;
        #1;
        check("rst_inst_addr", Inst_Addr, 64'h0);
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_halted", {63'h0, halted}, 64'h0);
        check("rst_out_instr", {32'h0, out_instr}, 64'h0);
        check("rst_out_pc", out_pc, 64'h0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] image [4];
        bit          br;
        logic [63:0] tgt;
        image = '{32'h0F05_3483, 32'h009A_84B3, 32'h0014_8493, 32'h0E95_3823};
        for (int i = 0; i < int'(Words); i++) begin
            imem[i] = (i < 4) ? image[i] : $urandom;
        end
        reset_n       = 1'b1;
        out_ready     = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 64'h0;
        #1;
        do_reset();

        // Free-running stream to the end of the image, then drained.
        repeat (22) step(1'b1, 1'b0, 64'h0);

        // Fill to full, one simultaneous pop+push, stall again, then drain.
        do_reset();
        repeat (6) step(1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b0, 64'h0);
        repeat (3) step(1'b0, 1'b0, 64'h0);
        repeat (8) step(1'b1, 1'b0, 64'h0);

        // Misaligned redirect with three entries queued.
        do_reset();
        repeat (3) step(1'b0, 1'b0, 64'h0);
        step(1'b0, 1'b1, 64'd6);
        repeat (4) step(1'b1, 1'b0, 64'h0);

        // Redirect past the image halts; redirect to 0 restarts.
        step(1'b1, 1'b1, 64'(MemBytes));
        repeat (3) step(1'b1, 1'b0, 64'h0);
        step(1'b1, 1'b1, 64'h0);
        repeat (3) step(1'b1, 1'b0, 64'h0);

        // Last word of the image via a truncated target.
        step(1'b1, 1'b1, 64'(MemBytes - 2));
        repeat (4) step(1'b1, 1'b0, 64'h0);

        // Asynchronous reset mid-stream, then restart from pc 0.
        step(1'b1, 1'b1, 64'h0);
        repeat (2) step(1'b1, 1'b0, 64'h0);
        #1;
        do_reset();
        repeat (5) step(1'b1, 1'b0, 64'h0);

        // Random back-pressure and redirects, including targets near the top of the space.
        repeat (400) begin
            br = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFFC | 64'($urandom_range(0, 3));
            else tgt = 64'($urandom_range(0, MemBytes + 8));
            step($urandom_range(0, 3) != 0, br, tgt);
        end
        repeat (30) step(1'b1, 1'b0, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
